// File: rtl/csa_sub_pipe.sv
// Two-stage carry-select subtractor with valid/ready flow control.
// Stage 1 resolves the low half and both upper-half candidates; stage 2 selects.
module csa_sub_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero,
  output logic             ovf
);

  localparam int H = WIDTH / 2;

  logic         s1_valid;
  logic         s2_valid;
  logic         s1_accept;
  logic         s2_accept;

  logic [H-1:0] s1_lo;
  logic [H-1:0] s1_hi0;
  logic [H-1:0] s1_hi1;
  logic         s1_lc;
  logic         s1_c0;
  logic         s1_c1;
  logic         s1_am;
  logic         s1_bm;

  logic [H-1:0] a_lo;
  logic [H-1:0] a_hi;
  logic [H-1:0] nb_lo;
  logic [H-1:0] nb_hi;
  logic [H:0]   lo_sum;
  logic [H:0]   hi0_sum;
  logic [H:0]   hi1_sum;

  logic [H-1:0]     sel_hi;
  logic             sel_c;
  logic [WIDTH-1:0] res;

  assign s2_accept = !s2_valid || out_ready;
  assign s1_accept = !s1_valid || s2_accept;
  assign in_ready  = s1_accept;
  assign out_valid = s2_valid;

  assign a_lo  = a[H-1:0];
  assign a_hi  = a[WIDTH-1:H];
  assign nb_lo = ~b[H-1:0];
  assign nb_hi = ~b[WIDTH-1:H];

  // Subtraction as a + ~b + ~b_in; the borrow is the inverted carry.
  assign lo_sum  = {1'b0, a_lo} + {1'b0, nb_lo}
                 + {{H{1'b0}}, ~b_in};
  assign hi0_sum = {1'b0, a_hi} + {1'b0, nb_hi};
  assign hi1_sum = {1'b0, a_hi} + {1'b0, nb_hi}
                 + {{H{1'b0}}, 1'b1};

  assign sel_hi = s1_lc ? s1_hi1 : s1_hi0;
  assign sel_c  = s1_lc ? s1_c1  : s1_c0;
  assign res    = {sel_hi, s1_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_hi0   <= '0;
      s1_hi1   <= '0;
      s1_lc    <= 1'b0;
      s1_c0    <= 1'b0;
      s1_c1    <= 1'b0;
      s1_am    <= 1'b0;
      s1_bm    <= 1'b0;
    end else if (s1_accept) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo  <= lo_sum[H-1:0];
        s1_lc  <= lo_sum[H];
        s1_hi0 <= hi0_sum[H-1:0];
        s1_c0  <= hi0_sum[H];
        s1_hi1 <= hi1_sum[H-1:0];
        s1_c1  <= hi1_sum[H];
        s1_am  <= a[WIDTH-1];
        s1_bm  <= b[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      b_out    <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_accept) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        diff  <= res;
        b_out <= ~sel_c;
        zero  <= (res == '0);
        ovf   <= (s1_am != s1_bm) && (res[WIDTH-1] != s1_am);
      end
    end
  end

endmodule

// File: tb/tb_csa_sub_pipe.sv
// Scoreboard bench for csa_sub_pipe: directed vectors, back-pressure,
// and mid-flight reset.
module tb_csa_sub_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        b_out;
  logic        zero;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  csa_sub_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: every output transfer is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got diff %h expected none", diff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.d);
        chk("b_out", 64'(b_out), 64'(e.bo));
        chk("zero", 64'(zero), 64'(e.z));
        chk("ovf", 64'(ovf), 64'(e.o));
      end
    end
  end

  task automatic send(input logic [63:0] x, input logic [63:0] y,
                      input logic bi, input exp_t e, input bit push,
                      output int waits);
    bit done;
    in_valid = 1'b1;
    a = x;
    b = y;
    b_in = bi;
    waits = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (push) sb.push_back(e);
      end else begin
        waits++;
        if (waits > 50) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout: got in_ready 0 expected 1");
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic exp_t mk(input logic [63:0] d, input logic bo,
                              input logic z, input logic o);
    exp_t e;
    e.d = d;
    e.bo = bo;
    e.z = z;
    e.o = o;
    return e;
  endfunction

  int w;
  exp_t bp1;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    b_in = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_diff", diff, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: result visible two cycles after the input cycle.
    send(64'd5, 64'd3, 1'b0, mk(64'd2, 0, 0, 0), 1, w);
    chk("first_accept_waits", 64'(w), 64'd0);
    chk("lat_s1_only", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_out_valid", 64'(out_valid), 64'd1);

    // Back-to-back stream with out_ready high.
    send(64'd0, 64'd1, 1'b0, mk('1, 1, 0, 0), 1, w);
    send(64'd7, 64'd7, 1'b0, mk(64'd0, 0, 1, 0), 1, w);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0,
         mk(64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1), 1, w);
    send(64'h0000_0001_0000_0000, 64'd0, 1'b1,
         mk(64'h0000_0000_FFFF_FFFF, 0, 0, 0), 1, w);
    send(64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0,
         mk(64'hDEAD_BEEF_0123_4567, 0, 0, 0), 1, w);
    send(64'h1234, 64'h1234, 1'b1, mk('1, 1, 0, 0), 1, w);
    send(64'h7FFF_FFFF_FFFF_FFFF, '1, 1'b0,
         mk(64'h8000_0000_0000_0000, 1, 0, 1), 1, w);
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure: 4 sets, out_ready low for 4 cycles.
    out_ready = 1'b0;
    bp1 = mk(64'd6, 0, 0, 0);
    fork
      begin
        send(64'd10, 64'd4, 1'b0, bp1, 1, w);
        send(64'd100, 64'd1, 1'b1, mk(64'd98, 0, 0, 0), 1, w);
        send(64'd3, 64'd5, 1'b0,
             mk(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0), 1, w);
        send(64'h0000_0002_0000_0000, 64'd1, 1'b0,
             mk(64'h0000_0001_FFFF_FFFF, 0, 0, 0), 1, w);
      end
      begin
        repeat (2) @(posedge clk);
        repeat (2) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_hold_diff", diff, bp1.d);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("bp_drain_valid", 64'(out_valid), 64'd1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Mid-flight reset with both stages full; results must never appear.
    out_ready = 1'b0;
    send(64'd50, 64'd1, 1'b0, mk(64'd49, 0, 0, 0), 0, w);
    send(64'd60, 64'd1, 1'b0, mk(64'd59, 0, 0, 0), 0, w);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_diff", diff, 64'd0);
    chk("arst_flags", 64'({b_out, zero, ovf}), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(64'd20, 64'd7, 1'b1, mk(64'd12, 0, 0, 0), 1, w);
    chk("post_rst_accept_waits", 64'(w), 64'd0);
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_lat", 64'(out_valid), 64'd1);

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
